// File: rtl/uart_rx_word_if.sv
// ---------------------------------------------------------------------------
// uart_rx_word_if
//   Bundles the serial input and the word-level outputs of uart_rx_word.
//
//   Signals:
//     rx          serial line into the receiver (idles high)
//     data_out    signed 32-bit word {b3,b2,b1,b0}, held until the next word
//     data_valid  one-cycle pulse when data_out updates
//     frame_err   one-cycle pulse on a bad guard or stop bit
//     sync_err    one-cycle pulse on a wrong terminator byte or a timeout
//     busy        high while the bit receiver is inside a frame
//
//   Modports:
//     master  the receiver: consumes rx, drives the word outputs
//     slave   the consumer: drives rx, observes the word outputs
// ---------------------------------------------------------------------------
interface uart_rx_word_if;
  logic               rx;
  logic signed [31:0] data_out;
  logic               data_valid;
  logic               frame_err;
  logic               sync_err;
  logic               busy;

  modport master (
    input  rx,
    output data_out, data_valid, frame_err, sync_err, busy
  );

  modport slave (
    output rx,
    input  data_out, data_valid, frame_err, sync_err, busy
  );
endinterface

// File: rtl/uart_rx_word.sv
// ---------------------------------------------------------------------------
// uart_rx_word
//   Receive side of the word-serialising UART link. Decodes 11-bit frames
//   (start, 8 data bits LSB first, guard bit = 0, stop) and reassembles each
//   6-byte record (4 data bytes little-endian, then 0x0D 0x0A) into one
//   signed 32-bit word with a single-cycle valid strobe. The first record
//   after reset is consumed while the assembler locks onto the terminator.
//
//   Ports:
//     clk    system clock, the only clock
//     rst_n  synchronous active-low reset
//     bus    uart_rx_word_if.master: rx in; data_out, data_valid,
//            frame_err, sync_err, busy out
//
//   Parameters:
//     BPS           last value of the bit-period counter (bit = BPS+1 clk)
//     BPS_2         clk cycles from the start edge to the start-bit sample
//     TIMEOUT_BITS  idle bit-times inside a record before giving up
//                   (present only with FRAME_TIMEOUT_EN)
//
//   Optional feature macro: FRAME_TIMEOUT_EN
//     Defined: an idle bit-time counter aborts a stalled record with a
//     sync_err pulse and sends the assembler back to HUNT.
//     Undefined: the assembler waits indefinitely mid-record.
// ---------------------------------------------------------------------------
module uart_rx_word #(
  parameter logic [9:0]  BPS          = 10'd868,
  parameter logic [9:0]  BPS_2        = 10'd434
`ifdef FRAME_TIMEOUT_EN
  , parameter logic [15:0] TIMEOUT_BITS = 16'd40
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_word_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_GUARD, S_STOP} bit_state_t;
  typedef enum logic [2:0] {A_HUNT, A_HUNT_LF, A_B0, A_B1, A_B2, A_B3, A_CR, A_LF} asm_state_t;

  logic       rx_meta, rx_s, rx_d;
  logic       start_edge;
  bit_state_t state;
  logic [9:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       guard_bad;
  logic       byte_rdy;
  logic       frame_err;
  asm_state_t asm_state;
  logic [7:0] b0, b1, b2, b3;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign start_edge = rx_d & ~rx_s;

  // Bit-level receiver. STOP returns straight to IDLE at the mid-stop
  // sample so a start bit following immediately is not missed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      guard_bad <= 1'b0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            cnt   <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == BPS_2) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line that is high again at mid-start was only a glitch.
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_DATA: begin
          if (cnt == BPS) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_GUARD;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_GUARD: begin
          if (cnt == BPS) begin
            cnt       <= '0;
            guard_bad <= rx_s;
            state     <= S_STOP;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_STOP: begin
          if (cnt == BPS) begin
            cnt <= '0;
            if (rx_s && !guard_bad) byte_rdy  <= 1'b1;
            else                    frame_err <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.frame_err = frame_err;

`ifdef FRAME_TIMEOUT_EN
  logic [9:0]  to_div;
  logic [15:0] to_bits;
  logic        in_record;

  assign in_record = asm_state inside {A_B1, A_B2, A_B3, A_CR, A_LF};

  // Counts whole idle bit-times while a record is partly received; any
  // start edge or leaving the record states starts the count afresh.
  always_ff @(posedge clk) begin
    if (!rst_n || start_edge || !in_record) begin
      to_div  <= '0;
      to_bits <= '0;
    end else if (state == S_IDLE) begin
      if (to_div == BPS) begin
        to_div  <= '0;
        to_bits <= to_bits + 16'd1;
      end else begin
        to_div <= to_div + 10'd1;
      end
    end
  end
`endif

  // Record assembler. A framing error abandons the record silently; the
  // byte value is taken from shift, which stays stable while byte_rdy is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_state      <= A_HUNT;
      b0             <= '0;
      b1             <= '0;
      b2             <= '0;
      b3             <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.sync_err   <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.sync_err   <= 1'b0;
      if (frame_err) begin
        asm_state <= A_HUNT;
      end else if (byte_rdy) begin
        case (asm_state)
          A_HUNT:    if (shift == 8'h0D) asm_state <= A_HUNT_LF;
          A_HUNT_LF: begin
            if (shift == 8'h0A)      asm_state <= A_B0;
            else if (shift != 8'h0D) asm_state <= A_HUNT;
          end
          A_B0: begin b0 <= shift; asm_state <= A_B1; end
          A_B1: begin b1 <= shift; asm_state <= A_B2; end
          A_B2: begin b2 <= shift; asm_state <= A_B3; end
          A_B3: begin b3 <= shift; asm_state <= A_CR; end
          A_CR: begin
            if (shift == 8'h0D) begin
              asm_state <= A_LF;
            end else begin
              bus.sync_err <= 1'b1;
              asm_state    <= A_HUNT;
            end
          end
          A_LF: begin
            if (shift == 8'h0A) begin
              bus.data_out   <= $signed({b3, b2, b1, b0});
              bus.data_valid <= 1'b1;
              asm_state      <= A_B0;
            end else begin
              bus.sync_err <= 1'b1;
              asm_state    <= A_HUNT;
            end
          end
          default: asm_state <= A_HUNT;
        endcase
      end
`ifdef FRAME_TIMEOUT_EN
      else if (in_record && to_bits == TIMEOUT_BITS) begin
        bus.sync_err <= 1'b1;
        asm_state    <= A_HUNT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_word
//   Self-checking bench for uart_rx_word with a shortened bit period
//   (BPS=15, BPS_2=7) so a full run stays short. Every byte put on the line
//   is logged in a stream queue (-1 marks a byte with a bad stop bit, -2 a
//   timeout); a byte-stream reference model derives the expected words and
//   error counts from that log.
// ---------------------------------------------------------------------------
module tb_uart_rx_word;

  localparam logic [9:0] BPS     = 10'd15;
  localparam logic [9:0] BPS_2   = 10'd7;
  localparam int         BIT_CYC = 16;
  // Start bit driven -> data_valid seen: 2 sync flops, edge detect, START
  // count, ten further bit periods, then byte_rdy and the output register.
  localparam int         LATENCY = 5 + 7 + 10 * BIT_CYC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_word_if bus ();

  uart_rx_word #(.BPS(BPS), .BPS_2(BPS_2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          total, bad;
  int          cyc;
  int          last_start_cyc, last_valid_cyc;
  int          n_frame, n_sync, overlap;
  bit          busy_seen;
  int          stream[$];
  logic [31:0] got_words[$];
  logic [31:0] exp_words[$];
  int          exp_sync, exp_frame;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.data_valid) begin
        got_words.push_back(bus.data_out);
        last_valid_cyc = cyc;
      end
      if (bus.frame_err) n_frame++;
      if (bus.sync_err)  n_sync++;
      if (bus.busy)      busy_seen = 1'b1;
      if (bus.data_valid && (bus.frame_err || bus.sync_err)) overlap++;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: scan the logged byte stream. Unlocked, look for an
  // adjacent 0D 0A pair; locked, take six-byte records, checking bytes 4
  // and 5 against the terminator. Bad-stop bytes and timeouts break lock.
  task automatic run_model();
    int          i, n, k, v;
    bit          locked, abort;
    logic [31:0] word;
    exp_words.delete();
    exp_sync  = 0;
    exp_frame = 0;
    foreach (stream[j]) if (stream[j] == -1) exp_frame++;
    locked = 1'b0;
    i      = 0;
    n      = stream.size();
    while (i < n) begin
      if (!locked) begin
        if (i + 1 < n && stream[i] == 13 && stream[i+1] == 10) begin
          locked = 1'b1;
          i += 2;
        end else begin
          i++;
        end
      end else begin
        abort = 1'b0;
        k     = 0;
        word  = '0;
        while (!abort && k < 6 && i < n) begin
          v = stream[i];
          i++;
          if (v == -1) begin
            locked = 1'b0; abort = 1'b1;
          end else if (v == -2) begin
            if (k > 0) begin exp_sync++; locked = 1'b0; abort = 1'b1; end
          end else if (k < 4) begin
            word[8*k +: 8] = v[7:0];
            k++;
          end else if (k == 4) begin
            if (v != 13) begin exp_sync++; locked = 1'b0; abort = 1'b1; end
            else k++;
          end else begin
            if (v != 10) begin exp_sync++; locked = 1'b0; abort = 1'b1; end
            else begin exp_words.push_back(word); k++; end
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] rand_byte(input bit allow_cr);
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    case ($urandom_range(0, 7))
      0:       v = 8'h0D;
      1:       v = 8'h0A;
      default: ;
    endcase
    if (!allow_cr && v == 8'h0D) v = 8'h0E;
    return v;
  endfunction

  function automatic logic [31:0] rand_word(input bit allow_cr);
    return {rand_byte(allow_cr), rand_byte(allow_cr), rand_byte(allow_cr), rand_byte(allow_cr)};
  endfunction

  // One 11-bit frame: start, data LSB first, guard 0, stop; then idle gap.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int gap);
    logic [10:0] fr;
    fr = {stop_bit, 1'b0, b, 1'b0};
    @(negedge clk);
    last_start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      bus.rx = fr[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (gap) @(negedge clk);
    if (stop_bit) stream.push_back(int'(b));
    else          stream.push_back(-1);
  endtask

  task automatic send_record(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_frame(w[8*k +: 8], 1'b1, gap);
    send_frame(8'h0D, 1'b1, gap);
    send_frame(8'h0A, 1'b1, gap);
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (2000) @(negedge clk);
    total++; if (bus.data_out !== 32'sd0) begin bad++; $display("[TB] FAIL reset_data_out got=%h want=0", bus.data_out); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_valid got=%b want=0", bus.data_valid); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err got=%b want=0", bus.frame_err); end
    total++; if (bus.sync_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_sync_err got=%b want=0", bus.sync_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (n_frame + n_sync + got_words.size() != 0 || busy_seen) begin
      bad++; $display("[TB] FAIL reset_idle_pulses got=%0d want=0", n_frame + n_sync + got_words.size() + int'(busy_seen));
    end
  endtask

  task automatic test_basic_record();
    int w0, lat;
    w0 = got_words.size();
    send_frame(8'h0D, 1'b1, 3);
    send_frame(8'h0A, 1'b1, 3);
    send_record(32'h12345678, 0);
    repeat (20) @(negedge clk);
    lat = last_valid_cyc - last_start_cyc;
    total++; if (got_words.size() != w0 + 1) begin bad++; $display("[TB] FAIL basic_count got=%0d want=%0d", got_words.size() - w0, 1); end
    total++; if (got_words[got_words.size()-1] !== 32'h12345678) begin bad++; $display("[TB] FAIL basic_word got=%h want=12345678", got_words[got_words.size()-1]); end
    total++; if (lat < LATENCY - 1 || lat > LATENCY + 1) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=%0d", lat, LATENCY); end
  endtask

  task automatic test_special_values();
    int w0;
    w0 = got_words.size();
    send_record(32'h0A0D0A0D, 2);
    send_record(32'hFFFFFFFF, 2);
    repeat (20) @(negedge clk);
    total++; if (got_words.size() != w0 + 2) begin bad++; $display("[TB] FAIL special_count got=%0d want=2", got_words.size() - w0); end
    total++; if (got_words[w0] !== 32'h0A0D0A0D) begin bad++; $display("[TB] FAIL special_word0 got=%h want=0a0d0a0d", got_words[w0]); end
    total++; if (got_words[w0+1] !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL special_word1 got=%h want=ffffffff", got_words[w0+1]); end
  endtask

  task automatic test_frame_error();
    logic [31:0] c, a, b;
    logic [7:0]  v;
    int          k, w0, f0;
    c  = rand_word(1'b0);
    a  = rand_word(1'b0);
    b  = rand_word(1'b0);
    k  = $urandom_range(0, 5);
    w0 = got_words.size();
    f0 = n_frame;
    for (int i = 0; i < 6; i++) begin
      v = (i < 4) ? c[8*i +: 8] : ((i == 4) ? 8'h0D : 8'h0A);
      send_frame(v, i != k, (i == k) ? 2 * BIT_CYC : 2);
    end
    repeat (20) @(negedge clk);
    total++; if (n_frame != f0 + 1) begin bad++; $display("[TB] FAIL frame_err_pulse got=%0d want=1 byte=%0d", n_frame - f0, k); end
    total++; if (got_words.size() != w0) begin bad++; $display("[TB] FAIL frame_no_valid got=%0d want=0", got_words.size() - w0); end
    send_record(a, 2);
    send_record(b, 2);
    repeat (20) @(negedge clk);
    run_model();
    total++; if (got_words[got_words.size()-1] !== b) begin bad++; $display("[TB] FAIL frame_recover_word got=%h want=%h", got_words[got_words.size()-1], b); end
    total++; if (got_words.size() != exp_words.size()) begin bad++; $display("[TB] FAIL frame_model_count got=%0d want=%0d", got_words.size(), exp_words.size()); end
  endtask

  task automatic test_glitch();
    logic [31:0] a;
    int          f0, w0, len;
    f0        = n_frame;
    len       = $urandom_range(1, 5);
    busy_seen = 1'b0;
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (len) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    total++; if (busy_seen !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy got=%b want=1", busy_seen); end
    total++; if (n_frame != f0) begin bad++; $display("[TB] FAIL glitch_frame_err got=%0d want=0", n_frame - f0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy_end got=%b want=0", bus.busy); end
    a  = rand_word(1'b1);
    w0 = got_words.size();
    send_record(a, 2);
    repeat (20) @(negedge clk);
    total++; if (got_words.size() != w0 + 1 || got_words[got_words.size()-1] !== a) begin
      bad++; $display("[TB] FAIL glitch_next_word got=%h want=%h", got_words[got_words.size()-1], a);
    end
  endtask

  task automatic test_sync_error();
    logic [31:0] a, b, c;
    int          s0, w0;
    a  = rand_word(1'b1);
    s0 = n_sync;
    w0 = got_words.size();
    for (int k = 0; k < 4; k++) send_frame(a[8*k +: 8], 1'b1, 2);
    send_frame(8'h0D, 1'b1, 2);
    send_frame(8'h0B, 1'b1, 2);
    repeat (20) @(negedge clk);
    total++; if (n_sync != s0 + 1) begin bad++; $display("[TB] FAIL sync_err_pulse got=%0d want=1", n_sync - s0); end
    total++; if (got_words.size() != w0) begin bad++; $display("[TB] FAIL sync_no_valid got=%0d want=0", got_words.size() - w0); end
    b = rand_word(1'b0);
    c = rand_word(1'b0);
    send_record(b, 2);
    send_record(c, 2);
    repeat (20) @(negedge clk);
    total++; if (got_words.size() != w0 + 1 || got_words[got_words.size()-1] !== c) begin
      bad++; $display("[TB] FAIL sync_recover_word got=%h want=%h", got_words[got_words.size()-1], c);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a;
    int          s0, w0;
    a  = rand_word(1'b1);
    s0 = n_sync;
    w0 = got_words.size();
    send_frame(a[7:0], 1'b1, 0);
    send_frame(a[15:8], 1'b1, 0);
`ifdef FRAME_TIMEOUT_EN
    repeat (30 * BIT_CYC) @(negedge clk);
    total++; if (n_sync != s0) begin bad++; $display("[TB] FAIL timeout_early got=%0d want=0", n_sync - s0); end
    repeat (15 * BIT_CYC) @(negedge clk);
    total++; if (n_sync != s0 + 1) begin bad++; $display("[TB] FAIL timeout_pulse got=%0d want=1", n_sync - s0); end
    stream.push_back(-2);
    send_record(rand_word(1'b0), 2);
    a = rand_word(1'b0);
    send_record(a, 2);
    repeat (20) @(negedge clk);
    total++; if (got_words.size() != w0 + 1 || got_words[got_words.size()-1] !== a) begin
      bad++; $display("[TB] FAIL timeout_recover_word got=%h want=%h", got_words[got_words.size()-1], a);
    end
`else
    repeat (45 * BIT_CYC) @(negedge clk);
    total++; if (n_sync != s0) begin bad++; $display("[TB] FAIL stall_sync_err got=%0d want=0", n_sync - s0); end
    send_frame(a[23:16], 1'b1, 0);
    send_frame(a[31:24], 1'b1, 0);
    send_frame(8'h0D, 1'b1, 0);
    send_frame(8'h0A, 1'b1, 0);
    repeat (20) @(negedge clk);
    total++; if (got_words.size() != w0 + 1 || got_words[got_words.size()-1] !== a) begin
      bad++; $display("[TB] FAIL stall_resume_word got=%h want=%h", got_words[got_words.size()-1], a);
    end
`endif
  endtask

  task automatic test_random_stream();
    repeat (10) begin
      if ($urandom_range(0, 4) == 0) send_frame(rand_byte(1'b1), 1'b1, $urandom_range(0, 8));
      send_record(rand_word(1'b1), $urandom_range(0, 12));
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_scoreboard();
    int n;
    run_model();
    total++; if (got_words.size() != exp_words.size()) begin bad++; $display("[TB] FAIL sb_word_count got=%0d want=%0d", got_words.size(), exp_words.size()); end
    n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int i = 0; i < n; i++) begin
      total++; if (got_words[i] !== exp_words[i]) begin bad++; $display("[TB] FAIL sb_word[%0d] got=%h want=%h", i, got_words[i], exp_words[i]); end
    end
    total++; if (n_sync != exp_sync) begin bad++; $display("[TB] FAIL sb_sync_count got=%0d want=%0d", n_sync, exp_sync); end
    total++; if (n_frame != exp_frame) begin bad++; $display("[TB] FAIL sb_frame_count got=%0d want=%0d", n_frame, exp_frame); end
    total++; if (overlap != 0) begin bad++; $display("[TB] FAIL sb_err_with_valid got=%0d want=0", overlap); end
  endtask

  task automatic test_reset_mid_byte();
    int f0, s0;
    f0 = n_frame;
    s0 = n_sync;
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (3 * BIT_CYC) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b want=0", bus.busy); end
    bus.rx = 1'b1;
    rst_n  = 1'b1;
    stream.delete();
    repeat (12 * BIT_CYC) @(negedge clk);
    total++; if (n_frame != f0) begin bad++; $display("[TB] FAIL midreset_frame_err got=%0d want=0", n_frame - f0); end
    total++; if (n_sync != s0) begin bad++; $display("[TB] FAIL midreset_sync_err got=%0d want=0", n_sync - s0); end
  endtask

  initial begin
    test_reset();
    test_basic_record();
    test_special_values();
    test_frame_error();
    test_glitch();
    test_sync_error();
    test_timeout();
    test_random_stream();
    test_scoreboard();
    test_reset_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
